// File: rtl/pll_pkg.sv
// pll_pkg: shared lock-state encoding and PLL error-code constants
package pll_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        HOLDOVER = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LAG  = 2'b01;
    localparam logic [1:0] ERR_LEAD = 2'b11;

endpackage

// File: rtl/pll_err_window.sv
// pll_err_window: per-window sample counter with error and lead/lag bias accumulators
import pll_pkg::*;

module pll_err_window #(
    parameter int LGWINDOW = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_clear,
    input  logic                       i_ce,
    input  logic [1:0]                 i_err,
    output logic                       o_close,
    output logic [LGWINDOW:0]          o_err_total,
    output logic signed [LGWINDOW+1:0] o_bias_total
);

    logic [LGWINDOW-1:0]        cnt_q;
    logic [LGWINDOW:0]          err_q;
    logic signed [LGWINDOW+1:0] bias_q;
    logic signed [LGWINDOW+1:0] bias_step;

    // Totals include the current sample so the closing sample lands in its own window
    assign o_close      = i_ce & (&cnt_q);
    assign o_err_total  = err_q + (LGWINDOW+1)'(i_err != ERR_NONE);
    assign bias_step    = (i_err == ERR_LAG) ? (LGWINDOW+2)'(1) : (i_err == ERR_LEAD) ? '1 : '0;
    assign o_bias_total = bias_q + bias_step;

    // Count samples and accumulate; restart both accumulators on the closing sample
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q  <= '0;
            err_q  <= '0;
            bias_q <= '0;
        end else if (i_clear) begin
            cnt_q  <= '0;
            err_q  <= '0;
            bias_q <= '0;
        end else if (i_ce) begin
            cnt_q  <= cnt_q + LGWINDOW'(1);
            err_q  <= o_close ? '0 : o_err_total;
            bias_q <= o_close ? '0 : o_bias_total;
        end
    end

endmodule

// File: rtl/pll_lock_detect.sv
// pll_lock_detect: windowed PLL error statistics, hysteretic lock FSM and phase-wrap tick
import pll_pkg::*;

module pll_lock_detect #(
    parameter int PHASE_BITS     = 32,
    parameter int LGWINDOW       = 8,
    parameter int LOCK_THRESH    = 4,
    parameter int UNLOCK_THRESH  = 32,
    parameter int LOCK_WINDOWS   = 4,
    parameter int UNLOCK_WINDOWS = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_ce,
    input  logic                       i_clear,
    input  logic [1:0]                 i_err,
    input  logic [PHASE_BITS-1:0]      i_phase,
    output logic                       o_locked,
    output logic [1:0]                 o_state,
    output logic [LGWINDOW:0]          o_err_count,
    output logic signed [LGWINDOW+1:0] o_bias,
    output logic                       o_window_stb,
    output logic                       o_wrap_stb
);

    localparam int GW = $clog2(LOCK_WINDOWS + 1);
    localparam int BW = $clog2(UNLOCK_WINDOWS + 1);

    logic                       close;
    logic [LGWINDOW:0]          err_total;
    logic signed [LGWINDOW+1:0] bias_total;
    state_t                     state_q;
    logic [GW-1:0]              good_q;
    logic [BW-1:0]              bad_q;
    logic                       prev_msb_q;
    logic                       msb;
    logic                       is_good;
    logic                       is_bad;
    logic                       unused_phase;

    pll_err_window #(.LGWINDOW(LGWINDOW)) u_win (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clear      (i_clear),
        .i_ce         (i_ce),
        .i_err        (i_err),
        .o_close      (close),
        .o_err_total  (err_total),
        .o_bias_total (bias_total)
    );

    // Only the phase MSB matters for wrap detection
    assign msb          = i_phase[PHASE_BITS-1];
    assign unused_phase = ^i_phase[PHASE_BITS-2:0];
    assign is_good      = 32'(err_total) <= 32'(LOCK_THRESH);
    assign is_bad       = 32'(err_total) > 32'(UNLOCK_THRESH);
    assign o_state      = state_q;

    // Lock FSM, stepped once per closed window on that window's error count
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= UNLOCKED;
            good_q   <= '0;
            bad_q    <= '0;
            o_locked <= 1'b0;
        end else if (i_clear) begin
            state_q  <= UNLOCKED;
            good_q   <= '0;
            bad_q    <= '0;
            o_locked <= 1'b0;
        end else if (close) begin
            case (state_q)
                UNLOCKED: if (is_good) begin
                    if (LOCK_WINDOWS == 1) begin
                        state_q  <= LOCKED;
                        o_locked <= 1'b1;
                    end else begin
                        state_q <= ACQUIRE;
                        good_q  <= GW'(1);
                    end
                end
                ACQUIRE: if (!is_good) begin
                    state_q <= UNLOCKED;
                    good_q  <= '0;
                end else if (32'(good_q) + 32'd1 >= 32'(LOCK_WINDOWS)) begin
                    state_q  <= LOCKED;
                    good_q   <= '0;
                    o_locked <= 1'b1;
                end else begin
                    good_q <= good_q + GW'(1);
                end
                LOCKED: if (is_bad) begin
                    if (UNLOCK_WINDOWS == 1) begin
                        state_q  <= UNLOCKED;
                        o_locked <= 1'b0;
                    end else begin
                        state_q <= HOLDOVER;
                        bad_q   <= BW'(1);
                    end
                end
                HOLDOVER: if (is_bad) begin
                    if (32'(bad_q) + 32'd1 >= 32'(UNLOCK_WINDOWS)) begin
                        state_q  <= UNLOCKED;
                        bad_q    <= '0;
                        o_locked <= 1'b0;
                    end else begin
                        bad_q <= bad_q + BW'(1);
                    end
                end else if (is_good) begin
                    state_q <= LOCKED;
                    bad_q   <= '0;
                end
                default: state_q <= UNLOCKED;
            endcase
        end
    end

    // Window totals, completion strobe and falling-MSB wrap strobe
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_err_count  <= '0;
            o_bias       <= '0;
            o_window_stb <= 1'b0;
            o_wrap_stb   <= 1'b0;
            prev_msb_q   <= 1'b0;
        end else if (i_clear) begin
            o_err_count  <= '0;
            o_bias       <= '0;
            o_window_stb <= 1'b0;
            o_wrap_stb   <= 1'b0;
            prev_msb_q   <= 1'b0;
        end else begin
            o_window_stb <= close;
            o_wrap_stb   <= i_ce & prev_msb_q & ~msb;
            if (i_ce) prev_msb_q <= msb;
            if (close) begin
                o_err_count <= err_total;
                o_bias      <= bias_total;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_detect.sv
// tb_pll_lock_detect: scoreboard bench for window statistics, lock FSM, wrap strobe and resets
module tb_pll_lock_detect;
    import pll_pkg::*;

    typedef struct {
        int err;
        int bias;
        int st;
        int lk;
        int samp;
    } win_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ce = 1'b0;
    logic              clr = 1'b0;
    logic [1:0]        err = 2'b00;
    logic [31:0]       phase = '0;
    logic [31:0]       step = '0;
    logic              locked;
    logic [1:0]        st;
    logic [4:0]        ecnt;
    logic signed [5:0] bias;
    logic              wstb;
    logic              pstb;

    int   vectors = 0;
    int   miscompares = 0;
    int   samples_done = 0;
    win_t wq[$];
    int   pq[$];

    pll_lock_detect #(
        .PHASE_BITS(32), .LGWINDOW(4), .LOCK_THRESH(2), .UNLOCK_THRESH(8),
        .LOCK_WINDOWS(4), .UNLOCK_WINDOWS(2)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_ce         (ce),
        .i_clear      (clr),
        .i_err        (err),
        .i_phase      (phase),
        .o_locked     (locked),
        .o_state      (st),
        .o_err_count  (ecnt),
        .o_bias       (bias),
        .o_window_stb (wstb),
        .o_wrap_stb   (pstb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic sample(input logic [1:0] e, input logic c);
        err = e;
        ce  = c;
        @(posedge clk);
        #1;
        if (c) begin
            samples_done++;
            phase = phase + step;
        end
    endtask

    // One 16-sample window: lag codes first, then lead, then illegal, rest in phase
    task automatic window(input int lag, input int lead, input int ill, input int st_exp, input bit toggle);
        logic [1:0] e;
        wq.push_back('{lag + lead + ill, lag - lead, st_exp, int'(st_exp >= 2), samples_done + 16});
        for (int i = 0; i < 16; i++) begin
            e = (i < lag) ? 2'b01 : (i < lag + lead) ? 2'b11 : (i < lag + lead + ill) ? 2'b10 : 2'b00;
            sample(e, 1'b1);
            if (toggle) sample(2'b00, 1'b0);
        end
    endtask

    always @(negedge clk) begin : monitor
        win_t w;
        int   p;
        if (wstb) begin
            if (wq.size() == 0) chk("window_unexpected", samples_done, -1);
            else begin
                w = wq.pop_front();
                chk("win_samp", samples_done, w.samp);
                chk("win_err", int'(ecnt), w.err);
                chk("win_bias", int'(bias), w.bias);
                chk("win_state", int'(st), w.st);
                chk("win_locked", int'(locked), w.lk);
            end
        end
        if (pstb) begin
            if (pq.size() == 0) chk("wrap_unexpected", samples_done, -1);
            else begin
                p = pq.pop_front();
                chk("wrap_samp", samples_done, p);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", int'(st), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(ecnt), 0);
        chk("rst_bias", int'(bias), 0);
        chk("rst_wstb", int'(wstb), 0);
        chk("rst_pstb", int'(pstb), 0);
        @(negedge clk);
        rst_n = 1'b1;
        samples_done = 0;
        repeat (3) window(0, 0, 0, 1, 0);
        window(0, 0, 0, 2, 0);
        window(12, 0, 0, 3, 0);
        window(5, 0, 0, 3, 0);
        window(0, 0, 0, 2, 0);
        window(12, 0, 0, 3, 0);
        window(12, 0, 0, 0, 0);
        window(0, 0, 0, 1, 0);
        window(0, 0, 0, 1, 0);
        window(0, 3, 0, 0, 0);
        repeat (3) window(0, 0, 0, 1, 0);
        window(0, 0, 0, 2, 0);
        window(10, 3, 1, 3, 0);
        repeat (5) sample(2'b01, 1'b1);
        clr = 1'b1;
        ce  = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        ce  = 1'b0;
        samples_done = 0;
        chk("clr_state", int'(st), 0);
        chk("clr_locked", int'(locked), 0);
        chk("clr_err", int'(ecnt), 0);
        chk("clr_bias", int'(bias), 0);
        phase = '0;
        step  = 32'h4000_0000;
        for (int k = 5; k <= 33; k += 4) pq.push_back(k);
        window(0, 0, 0, 1, 0);
        window(0, 0, 0, 1, 1);
        step = '0;
        window(2, 0, 0, 1, 0);
        repeat (7) sample(2'b01, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", int'(st), 0);
        chk("arst_err", int'(ecnt), 0);
        chk("arst_bias", int'(bias), 0);
        @(negedge clk);
        rst_n = 1'b1;
        samples_done = 0;
        window(0, 0, 0, 1, 0);
        repeat (3) sample(2'b00, 1'b0);
        chk("win_q_left", wq.size(), 0);
        chk("wrap_q_left", pq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
